// File: rtl/rf_pkg.sv
// Shared register-file types: data/address widths and the writeback entry layout.
// Latency: none (types and constants only).
// Backpressure: n/a.
//
// Also used by reg_file users, so keep widths in sync with the 8x8 register file.
package rf_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/fifo.sv
// Generic circular FIFO that also exposes its storage, occupancy mask and head pointer.
// Latency: push at edge N is visible at pop_dat in cycle N+1; pop_dat is combinational from head.
// Backpressure: push_rdy = !full from registered count only; pop happens when pop_vld && pop_rdy.
//
// Ports: clk, reset (sync, active-high); push_vld/push_rdy/push_dat; pop_vld/pop_rdy/pop_dat;
//        count (occupied entries); head_ptr, occ_mask, mem_flat (read-only view of the storage).
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_vld,
    output logic                   push_rdy,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [CW-1:0]          count,
    output logic [AW-1:0]          head_ptr,
    output logic [DEPTH-1:0]       occ_mask,
    output logic [DEPTH*WIDTH-1:0] mem_flat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    off;

    // Ready looks only at the registered count: a pop in a full cycle does not
    // reopen the queue until the next cycle.
    assign push_rdy = (cnt != CW'(DEPTH));
    assign pop_vld  = (cnt != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    assign pop_dat  = mem[rd_ptr];
    assign count    = cnt;
    assign head_ptr = rd_ptr;

    // DEPTH is a power of two, so pointer wrap is just natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage has no reset; stale contents are masked out by occ_mask.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        occ_mask = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = AW'(i) - rd_ptr;
            occ_mask[i] = ({1'b0, off} < cnt);
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem[i];
        end
    end

endmodule

// File: rtl/rf_wb_match.sv
// Newest-match search of one read address against all pending writeback entries.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a hit stalls or bypasses.
//
// Ports: entries (flattened {addr,data} per slot), vld (occupied slots), head (oldest slot),
//        rd_addr (address being read); hit (any pending match), data (newest matching data).
module rf_wb_match #(
    parameter int AW    = 3,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int EW   = AW + DW
) (
    input  logic [DEPTH*EW-1:0] entries,
    input  logic [DEPTH-1:0]    vld,
    input  logic [PW-1:0]       head,
    input  logic [AW-1:0]       rd_addr,
    output logic                hit,
    output logic [DW-1:0]       data
);

    logic [PW-1:0] slot;
    logic [EW-1:0] e;

    // Walk from oldest (head) to newest; a later match overrides an earlier one,
    // so the surviving data belongs to the write closest to the tail.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        e    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            e    = entries[int'(slot)*EW +: EW];
            if (vld[slot] && (e[EW-1 -: AW] == rd_addr)) begin
                hit  = 1'b1;
                data = e[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-side front end of the 8x8 register file: queues writebacks, drains one per cycle, resolves RAW.
// Latency: accepted at edge N -> rf_wr_en in cycle N+1 -> file written at edge N+1.
// Backpressure: wb_ready = !full (registered count); drain never stalls except via drain_hold.
//
// Ports: clk, reset (sync, active-high); wb_valid/wb_ready/wb_addr/wb_data (requests in);
//        rf_wr_en/rf_wr_addr/rf_dat_in (file write port); rd_addrA/B, rf_datA/B (raw reads);
//        datA_out/datB_out (resolved reads); hazard (stall request); count (occupancy);
//        drain_hold (bring-up hook: freezes the drain so the queue can be filled; tie 0 in use).
// Build option: define RF_WB_BYPASS_EN to forward pending data instead of raising hazard.
module rf_writeback_queue
    import rf_pkg::*;
#(
    parameter int pw    = 3,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [pw-1:0]           wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    rf_wr_en,
    output logic [pw-1:0]           rf_wr_addr,
    output logic [DATA_W-1:0]       rf_dat_in,
    input  logic [pw-1:0]           rd_addrA,
    input  logic [pw-1:0]           rd_addrB,
    input  logic [DATA_W-1:0]       rf_datA,
    input  logic [DATA_W-1:0]       rf_datB,
    output logic [DATA_W-1:0]       datA_out,
    output logic [DATA_W-1:0]       datB_out,
    output logic                    hazard,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    drain_hold
);

    localparam int EW = pw + DATA_W;
    localparam int PW = $clog2(DEPTH);

    logic                  q_vld;
    logic                  q_pop_rdy;
    logic [EW-1:0]         q_head_dat;
    logic [PW-1:0]         q_head_ptr;
    logic [DEPTH-1:0]      q_occ;
    logic [DEPTH*EW-1:0]   q_mem;
    logic                  match_hitA;
    logic                  match_hitB;
    logic [DATA_W-1:0]     match_datA;
    logic [DATA_W-1:0]     match_datB;

    // Gating the write enable with reset keeps a mid-operation reset from
    // letting the current head slip into the file on the reset edge.
    assign q_pop_rdy = !drain_hold && !reset;
    assign rf_wr_en  = q_vld && q_pop_rdy;

    fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push_vld (wb_valid),
        .push_rdy (wb_ready),
        .push_dat ({wb_addr, wb_data}),
        .pop_vld  (q_vld),
        .pop_rdy  (q_pop_rdy),
        .pop_dat  (q_head_dat),
        .count    (count),
        .head_ptr (q_head_ptr),
        .occ_mask (q_occ),
        .mem_flat (q_mem)
    );

    assign rf_wr_addr = q_head_dat[EW-1 -: pw];
    assign rf_dat_in  = q_head_dat[DATA_W-1:0];

    // The head is included in the search: it is written at the end of this
    // cycle, so the file's combinational read still returns the old value.
    rf_wb_match #(
        .AW    (pw),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_match_a (
        .entries (q_mem),
        .vld     (q_occ),
        .head    (q_head_ptr),
        .rd_addr (rd_addrA),
        .hit     (match_hitA),
        .data    (match_datA)
    );

    rf_wb_match #(
        .AW    (pw),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_match_b (
        .entries (q_mem),
        .vld     (q_occ),
        .head    (q_head_ptr),
        .rd_addr (rd_addrB),
        .hit     (match_hitB),
        .data    (match_datB)
    );

`ifdef RF_WB_BYPASS_EN
    assign datA_out = match_hitA ? match_datA : rf_datA;
    assign datB_out = match_hitB ? match_datB : rf_datB;
    assign hazard   = 1'b0;
`else
    logic unused_match_dat;
    assign unused_match_dat = ^{match_datA, match_datB};

    // The queue keeps draining while this is high, so the stall clears
    // within count cycles.
    assign datA_out = rf_datA;
    assign datB_out = rf_datB;
    assign hazard   = match_hitA || match_hitB;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_valid;
    logic       wb_ready;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       rf_wr_en;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_dat_in;
    logic [2:0] rd_addrA;
    logic [2:0] rd_addrB;
    logic [7:0] rf_datA;
    logic [7:0] rf_datB;
    logic [7:0] datA_out;
    logic [7:0] datB_out;
    logic       hazard;
    logic [2:0] count;
    logic       drain_hold;

    int checks = 0;
    int errors = 0;

    // Register file model driven by the DUT write port.
    logic [7:0] regs [8];
    logic       rf_clr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (rf_wr_en) begin
            regs[rf_wr_addr] <= rf_dat_in;
        end
    end

    assign rf_datA = regs[rd_addrA];
    assign rf_datB = regs[rd_addrB];

    rf_writeback_queue #(.pw(3), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_dat_in  (rf_dat_in),
        .rd_addrA   (rd_addrA),
        .rd_addrB   (rd_addrB),
        .rf_datA    (rf_datA),
        .rf_datB    (rf_datB),
        .datA_out   (datA_out),
        .datB_out   (datB_out),
        .hazard     (hazard),
        .count      (count),
        .drain_hold (drain_hold)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rf_clr = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_addrA = '0; rd_addrB = '0; drain_hold = 1'b0;
        step(); step();
        reset = 1'b0; rf_clr = 1'b0;
        settle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, expected 0", rf_wr_en); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", wb_ready); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b, expected 0", hazard); end
        step();
    endtask

    task automatic test_basic();
        rd_addrA = 3'd3; rd_addrB = 3'd0;
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'hA5;
        settle();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL basic_unpending_req: hazard %b, expected 0", hazard); end
        step();
        wb_valid = 1'b0;
        settle();
        checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en: got %b, expected 1", rf_wr_en); end
        checks++; if (rf_wr_addr !== 3'd3) begin errors++; $display("FAIL basic_wr_addr: got %0d, expected 3", rf_wr_addr); end
        checks++; if (rf_dat_in !== 8'hA5) begin errors++; $display("FAIL basic_wr_data: got %h, expected a5", rf_dat_in); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d, expected 1", count); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (datA_out !== 8'hA5) begin errors++; $display("FAIL basic_bypassA: got %h, expected a5", datA_out); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL basic_hazard: got %b, expected 1", hazard); end
`endif
        step();
        settle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d, expected 0", count); end
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL basic_idle_wr_en: got %b, expected 0", rf_wr_en); end
        checks++; if (datA_out !== 8'hA5) begin errors++; $display("FAIL basic_file_r3: got %h, expected a5", datA_out); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL basic_hazard_clear: got %b, expected 0", hazard); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_addr;
        rd_addrA = 3'd0; rd_addrB = 3'd0;
        drain_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1;
            wb_addr  = (i < 4) ? 3'(i + 4) : 3'd1;
            wb_data  = 8'(8'h10 + i);
            settle();
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d, expected %0d", i, count, i); end
            checks++; if (wb_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %b, expected %b", i, wb_ready, (i < 4)); end
            step();
        end
        settle();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d, expected 4", count); end
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL full_hold_wr_en: got %b, expected 0", rf_wr_en); end
        step();
        drain_hold = 1'b0;
        for (int j = 0; j < 5; j++) begin
            exp_addr = (j < 4) ? 3'(j + 4) : 3'd1;
            settle();
            if (j == 0) begin
                checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b, expected 0", wb_ready); end
            end
            checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL drain_wr_en[%0d]: got %b, expected 1", j, rf_wr_en); end
            checks++; if (rf_wr_addr !== exp_addr) begin errors++; $display("FAIL drain_addr[%0d]: got %0d, expected %0d", j, rf_wr_addr, exp_addr); end
            checks++; if (rf_dat_in !== 8'(8'h10 + j)) begin errors++; $display("FAIL drain_data[%0d]: got %h, expected %h", j, rf_dat_in, 8'(8'h10 + j)); end
            step();
            if (j == 1) wb_valid = 1'b0;
        end
        settle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty: got %0d, expected 0", count); end
        step();
    endtask

    task automatic test_raw_same_reg();
        drain_hold = 1'b1; rd_addrA = 3'd2; rd_addrB = 3'd0;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h11;
        step();
        wb_data = 8'h22;
        step();
        wb_valid = 1'b0;
        settle();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL raw_count: got %0d, expected 2", count); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (datA_out !== 8'h22) begin errors++; $display("FAIL raw_newest: got %h, expected 22", datA_out); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_hazard: got %b, expected 0", hazard); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_hazard: got %b, expected 1", hazard); end
        checks++; if (datA_out !== 8'h00) begin errors++; $display("FAIL raw_raw_read: got %h, expected 00", datA_out); end
`endif
        step();
        drain_hold = 1'b0;
        settle();
        checks++; if (rf_dat_in !== 8'h11) begin errors++; $display("FAIL raw_order1: got %h, expected 11", rf_dat_in); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (datA_out !== 8'h22) begin errors++; $display("FAIL raw_newest_head: got %h, expected 22", datA_out); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_hazard2: got %b, expected 1", hazard); end
`endif
        step();
        settle();
        checks++; if (rf_dat_in !== 8'h22) begin errors++; $display("FAIL raw_order2: got %h, expected 22", rf_dat_in); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (datA_out !== 8'h22) begin errors++; $display("FAIL raw_last: got %h, expected 22", datA_out); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_hazard3: got %b, expected 1", hazard); end
        checks++; if (datA_out !== 8'h11) begin errors++; $display("FAIL raw_mid_file: got %h, expected 11", datA_out); end
`endif
        step();
        settle();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_clear: got %b, expected 0", hazard); end
        checks++; if (datA_out !== 8'h22) begin errors++; $display("FAIL raw_final: got %h, expected 22", datA_out); end
        step();
    endtask

    task automatic test_port_b();
        drain_hold = 1'b1; rd_addrA = 3'd1; rd_addrB = 3'd5;
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 8'h7E;
        step();
        wb_valid = 1'b0;
        settle();
        checks++; if (datA_out !== 8'h14) begin errors++; $display("FAIL portb_a_nomatch: got %h, expected 14", datA_out); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (datB_out !== 8'h7E) begin errors++; $display("FAIL portb_bypass: got %h, expected 7e", datB_out); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL portb_hazard: got %b, expected 0", hazard); end
`else
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL portb_hazard: got %b, expected 1", hazard); end
        checks++; if (datB_out !== 8'h11) begin errors++; $display("FAIL portb_raw: got %h, expected 11", datB_out); end
`endif
        step();
        drain_hold = 1'b0;
        step();
        settle();
        checks++; if (datB_out !== 8'h7E) begin errors++; $display("FAIL portb_written: got %h, expected 7e", datB_out); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL portb_clear: got %b, expected 0", hazard); end
        step();
    endtask

    task automatic test_reset_mid();
        drain_hold = 1'b1; rd_addrA = 3'd6; rd_addrB = 3'd7;
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 8'hAA; step();
        wb_addr = 3'd6; wb_data = 8'hBB; step();
        wb_addr = 3'd7; wb_data = 8'hCC; step();
        wb_valid = 1'b0;
        settle();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_count3: got %0d, expected 3", count); end
        step();
        reset = 1'b1; drain_hold = 1'b0;
        settle();
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_in_reset: got %b, expected 0", rf_wr_en); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en[%0d]: got %b, expected 0", k, rf_wr_en); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count[%0d]: got %0d, expected 0", k, count); end
            step();
        end
        settle();
        checks++; if (datA_out !== 8'h12) begin errors++; $display("FAIL rmid_r6: got %h, expected 12", datA_out); end
        checks++; if (datB_out !== 8'h13) begin errors++; $display("FAIL rmid_r7: got %h, expected 13", datB_out); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rmid_hazard: got %b, expected 0", hazard); end
        step();
        rd_addrA = 3'd0;
        settle();
        checks++; if (datA_out !== 8'h00) begin errors++; $display("FAIL rmid_r0: got %h, expected 00", datA_out); end
        step();
    endtask

    task automatic test_push_pop_wrap();
        logic [2:0] ea;
        logic [7:0] ed;
        rd_addrA = 3'd0; rd_addrB = 3'd0;
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 8'h30; step();
        wb_addr = 3'd2; wb_data = 8'h31; step();
        drain_hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wb_valid = 1'b1; wb_addr = 3'(k); wb_data = 8'(8'h40 + k);
            ea = (k < 2) ? 3'(k + 1) : 3'(k - 2);
            ed = (k < 2) ? 8'(8'h30 + k) : 8'(8'h40 + k - 2);
            settle();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count[%0d]: got %0d, expected 2", k, count); end
            checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL pp_ready[%0d]: got %b, expected 1", k, wb_ready); end
            checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL pp_wr_en[%0d]: got %b, expected 1", k, rf_wr_en); end
            checks++; if (rf_wr_addr !== ea) begin errors++; $display("FAIL pp_addr[%0d]: got %0d, expected %0d", k, rf_wr_addr, ea); end
            checks++; if (rf_dat_in !== ed) begin errors++; $display("FAIL pp_data[%0d]: got %h, expected %h", k, rf_dat_in, ed); end
            step();
        end
        wb_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (rf_wr_addr !== 3'(k)) begin errors++; $display("FAIL pp_tail_addr[%0d]: got %0d, expected %0d", k, rf_wr_addr, k); end
            checks++; if (rf_dat_in !== 8'(8'h48 + k)) begin errors++; $display("FAIL pp_tail_data[%0d]: got %h, expected %h", k, rf_dat_in, 8'(8'h48 + k)); end
            step();
        end
        settle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d, expected 0", count); end
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL pp_idle: got %b, expected 0", rf_wr_en); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_raw_same_reg();
        test_port_b();
        test_reset_mid();
        test_push_pop_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
